// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron slice: default datapath widths,
// weight/current types and the firing threshold used by the downstream neuron.
package snn_pkg;

   localparam int unsigned SNN_WEIGHT_W = 8;
   localparam int unsigned SNN_OUT_W    = 8;

   typedef logic [SNN_WEIGHT_W-1:0] weight_t;
   typedef logic [SNN_OUT_W-1:0]    current_t;

   localparam current_t THRESHOLD = current_t'(100);

endpackage

// File: rtl/synapse_partial_sum.sv
// Combinational masked sum of N packed weights; the sum width grows by
// $clog2(N) bits, so it cannot overflow.
module synapse_partial_sum #(
   parameter int unsigned N        = 4,
   parameter int unsigned WEIGHT_W = 8
) (
   input  logic [N-1:0]                      mask_i,
   input  logic [N*WEIGHT_W-1:0]             weights_i,
   output logic [WEIGHT_W+$clog2(N)-1:0]     sum_o
);

   localparam int unsigned SUM_W = WEIGHT_W + $clog2(N);

   logic [SUM_W-1:0] acc;

   always_comb begin
      acc = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (mask_i[i]) begin
            acc = acc + SUM_W'(weights_i[i*WEIGHT_W +: WEIGHT_W]);
         end
      end
   end

   assign sum_o = acc;

endmodule

// File: rtl/synapse_weight_array.sv
// Spike-to-current synapse array: per-synapse runtime-writable weights, two-stage
// pipelined weighted sum saturated to OUT_W bits. Define SYN_EDGE_DETECT_EN to make
// each spike line count only on its rising edge instead of its level.
module synapse_weight_array
   import snn_pkg::*;
#(
   parameter int unsigned         NUM_IN      = 8,
   parameter int unsigned         WEIGHT_W    = SNN_WEIGHT_W,
   parameter int unsigned         OUT_W       = SNN_OUT_W,
   parameter logic [WEIGHT_W-1:0] WEIGHT_INIT = WEIGHT_W'(16)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_IN-1:0]         spike_in,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_IN)-1:0] cfg_addr,
   input  logic [WEIGHT_W-1:0]       cfg_wdata,
   output logic [OUT_W-1:0]          syn_current,
   output logic                      syn_active,
   output logic                      syn_sat
);

   localparam int unsigned AW   = $clog2(NUM_IN);
   localparam int unsigned HALF = NUM_IN / 2;
   localparam int unsigned HW   = WEIGHT_W + $clog2(HALF);
   localparam int unsigned PW   = WEIGHT_W + AW;
   localparam int unsigned FW   = PW + 1;
   localparam int unsigned CW   = (FW > OUT_W) ? FW : OUT_W;

   logic [WEIGHT_W-1:0]      w_q [NUM_IN];
   logic [HALF*WEIGHT_W-1:0] w_lo;
   logic [HALF*WEIGHT_W-1:0] w_hi;
   logic [NUM_IN-1:0]        spike_eff;
   logic [HW-1:0]            sum_lo;
   logic [HW-1:0]            sum_hi;

   logic [PW-1:0]    lo_d, lo_q, hi_d, hi_q;
   logic             any_d, any_q;
   logic [FW-1:0]    full;
   logic             clip;
   logic [OUT_W-1:0] cur_d, cur_q;
   logic             sat_d, sat_q;
   logic             act_q;

   // Stage 1 reads w_q before the write lands, so a same-cycle write uses the old weight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            w_q[i] <= WEIGHT_INIT;
         end
      end else if (cfg_we) begin
         w_q[cfg_addr] <= cfg_wdata;
      end
   end

   always_comb begin
      w_lo = '0;
      w_hi = '0;
      for (int unsigned i = 0; i < HALF; i++) begin
         w_lo[i*WEIGHT_W +: WEIGHT_W] = w_q[i];
         w_hi[i*WEIGHT_W +: WEIGHT_W] = w_q[i+HALF];
      end
   end

`ifdef SYN_EDGE_DETECT_EN
   logic [NUM_IN-1:0] spike_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_prev_q <= '0;
      end else begin
         spike_prev_q <= spike_in;
      end
   end

   assign spike_eff = spike_in & ~spike_prev_q;
`else
   assign spike_eff = spike_in;
`endif

   synapse_partial_sum #(.N(HALF), .WEIGHT_W(WEIGHT_W)) u_sum_lo (
      .mask_i    (spike_eff[HALF-1:0]),
      .weights_i (w_lo),
      .sum_o     (sum_lo)
   );

   synapse_partial_sum #(.N(HALF), .WEIGHT_W(WEIGHT_W)) u_sum_hi (
      .mask_i    (spike_eff[NUM_IN-1:HALF]),
      .weights_i (w_hi),
      .sum_o     (sum_hi)
   );

   always_comb begin
      lo_d  = PW'(sum_lo);
      hi_d  = PW'(sum_hi);
      any_d = |spike_eff;
   end

   always_comb begin
      full  = {1'b0, lo_q} + {1'b0, hi_q};
      clip  = CW'(full) > CW'({OUT_W{1'b1}});
      cur_d = clip ? '1 : OUT_W'(full);
      sat_d = clip;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q  <= '0;
         hi_q  <= '0;
         any_q <= 1'b0;
         cur_q <= '0;
         sat_q <= 1'b0;
         act_q <= 1'b0;
      end else begin
         lo_q  <= lo_d;
         hi_q  <= hi_d;
         any_q <= any_d;
         cur_q <= cur_d;
         sat_q <= sat_d;
         act_q <= any_q;
      end
   end

   assign syn_current = cur_q;
   assign syn_active  = act_q;
   assign syn_sat     = sat_q;

endmodule
